// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types, constants and big-endian lane helpers for the
// MIPS data-memory responder.
package mips_mem_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Lane 0 is the most significant byte of the word.
  function automatic logic [31:0] pack_lanes(input byte_t lanes [0:BYTES_PER_WORD-1]);
    logic [31:0] word;
    word = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      word[31-8*i -: 8] = lanes[i];
    end
    return word;
  endfunction

  function automatic byte_t unpack_lane(input logic [31:0] word, input int lane);
    return word[31-8*lane -: 8];
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: single-port word array with synchronous write and a
// registered read port that only updates on a completing load.
module data_mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // The read register doubles as the load-data holding register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data memory with req/ready handshake and programmable latency.
// Define DATA_MEM_ERR_EN to flag misaligned and out-of-range accesses on mem_err.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write_en,
  input  byte_t       mem_data_in [0:BYTES_PER_WORD-1],
  input  logic        halted,
  output byte_t       mem_data_out [0:BYTES_PER_WORD-1],
  output logic        mem_ready,
  output logic        mem_err
);

  localparam bit         SINGLE     = (LATENCY == 1);
  localparam logic [3:0] LAT_RELOAD = 4'(LATENCY - 1);

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              commit;
  logic              req_err;

  logic [ADDR_W-1:0] idx_q;
  logic              we_q;
  logic              err_pend_q;
  logic [31:0]       wdata_q;

  logic [ADDR_W-1:0] acc_idx;
  logic              acc_we;
  logic              acc_err;
  logic [31:0]       acc_wdata;
  logic              array_en;
  logic [31:0]       rdata;

  logic              ready_q;
  logic              err_q;

`ifdef DATA_MEM_ERR_EN
  assign req_err = (mem_addr[1:0] != 2'b00) || (mem_addr[31:ADDR_W+2] != '0);
`else
  assign req_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
`endif

  assign accept = mem_req && !halted && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (SINGLE) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_RELOAD;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= commit;
      err_q   <= commit && acc_err;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      idx_q      <= '0;
      we_q       <= 1'b0;
      err_pend_q <= 1'b0;
      wdata_q    <= '0;
    end else if (accept) begin
      idx_q      <= mem_addr[ADDR_W+1:2];
      we_q       <= mem_write_en;
      err_pend_q <= req_err;
      wdata_q    <= pack_lanes(mem_data_in);
    end
  end

  // With single-cycle latency the array is accessed on the acceptance edge itself.
  assign acc_idx   = SINGLE ? mem_addr[ADDR_W+1:2]    : idx_q;
  assign acc_we    = SINGLE ? mem_write_en            : we_q;
  assign acc_err   = SINGLE ? req_err                 : err_pend_q;
  assign acc_wdata = SINGLE ? pack_lanes(mem_data_in) : wdata_q;
  assign array_en  = commit && !acc_err;

  data_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .rst_b(rst_b),
    .en   (array_en),
    .we   (acc_we),
    .addr (acc_idx),
    .wdata(acc_wdata),
    .rdata(rdata)
  );

  for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_lane
    assign mem_data_out[g] = unpack_lane(rdata, g);
  end

  assign mem_ready = ready_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: three responders (LATENCY 1, 3, 4) checked by a
// scoreboard against a word-level memory model.
`timescale 1ns/1ps
module tb_data_mem_responder;
  import mips_mem_pkg::*;

  localparam int NI     = 3;
  localparam int ADDR_W = 10;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  logic        clk   = 1'b0;
  logic        rst_b = 1'b1;
  logic        req   [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic        halt  [NI];
  logic        ready [NI];
  logic        err   [NI];
  logic [31:0] rdata [NI];

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    byte_t din_l  [0:3];
    byte_t dout_l [0:3];
    for (genvar b = 0; b < 4; b++) begin : g_b
      assign din_l[b] = wdata[g][31-8*b -: 8];
    end
    assign rdata[g] = {dout_l[0], dout_l[1], dout_l[2], dout_l[3]};

    data_mem_responder #(
      .ADDR_W (ADDR_W),
      .LATENCY(lat_of(g))
    ) u_dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .mem_req     (req[g]),
      .mem_addr    (addr[g]),
      .mem_write_en(we[g]),
      .mem_data_in (din_l),
      .halted      (halt[g]),
      .mem_data_out(dout_l),
      .mem_ready   (ready[g]),
      .mem_err     (err[g])
    );
  end

  typedef struct {
    int          inst;
    int          due;
    logic        is_store;
    logic        err;
    logic [31:0] data;
    int          idx;
    logic [31:0] old;
  } exp_t;

  exp_t        expq [$];
  exp_t        mon_e;
  logic [31:0] mdl [NI][1024];
  logic [31:0] last_load [NI];
  int          last_acc [NI];
  int          compared   = 0;
  int          mismatched = 0;

  function automatic logic addr_err(input logic [31:0] a);
`ifdef DATA_MEM_ERR_EN
    return (a % 4 != 0) || (a >= (32'd4 << ADDR_W));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a / 4) % (1 << ADDR_W));
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s inst%0d: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, inst, act, exp, cycle);
    end
  endtask

  // Drive one cycle of inputs; the model decides acceptance for the coming edge.
  task automatic applyStimulus(input int inst, input logic r, input logic w,
                               input logic [31:0] a, input logic [31:0] d, input logic h);
    exp_t e;
    int   edge_n;
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      req[i]  = 1'b0;
      halt[i] = 1'b0;
    end
    req[inst]   = r;
    we[inst]    = w;
    addr[inst]  = a;
    wdata[inst] = d;
    halt[inst]  = h;
    edge_n = cycle + 1;
    if (r && !h && rst_b && (edge_n >= last_acc[inst] + lat_of(inst))) begin
      last_acc[inst] = edge_n;
      e.inst     = inst;
      e.due      = edge_n + lat_of(inst) - 1;
      e.is_store = w;
      e.err      = addr_err(a);
      e.idx      = word_idx(a);
      e.old      = mdl[inst][e.idx];
      if (w) begin
        e.data = last_load[inst];
        if (!e.err) mdl[inst][e.idx] = d;
      end else begin
        e.data = e.err ? last_load[inst] : mdl[inst][e.idx];
        last_load[inst] = e.data;
      end
      expq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic doOp(input int inst, input logic w, input logic [31:0] a, input logic [31:0] d);
    applyStimulus(inst, 1'b1, w, a, d, 1'b0);
    idle(lat_of(inst));
  endtask

  // Anything still in flight is aborted; an uncommitted store never lands.
  task automatic applyReset(input int n);
    exp_t e;
    @(negedge clk);
    #1;
    rst_b = 1'b0;
    while (expq.size() > 0) begin
      e = expq.pop_back();
      if (e.is_store && !e.err) mdl[e.inst][e.idx] = e.old;
    end
    for (int i = 0; i < NI; i++) begin
      last_load[i] = '0;
      last_acc[i]  = -100;
      req[i]       = 1'b0;
      halt[i]      = 1'b0;
    end
    repeat (n) @(negedge clk);
    #1;
    rst_b = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_b) begin
        checkOutput("ready_in_reset", i, 32'(ready[i]), 32'h0);
      end else if (ready[i]) begin
        if (expq.size() == 0 || expq[0].inst != i) begin
          checkOutput("spurious_ready", i, 32'(ready[i]), 32'h0);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("ready_cycle", i, 32'(cycle), 32'(mon_e.due));
          checkOutput("mem_err", i, 32'(err[i]), 32'(mon_e.err));
          checkOutput("data_out", i, rdata[i], mon_e.data);
        end
      end
    end
    if (rst_b && expq.size() > 0 && expq[0].due < cycle) begin
      mon_e = expq.pop_front();
      checkOutput("missed_ready", mon_e.inst, 32'(cycle), 32'(mon_e.due));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        r, w, h;
    logic [31:0] a, d;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; halt[i] = 1'b0;
      last_load[i] = '0;
      last_acc[i]  = -100;
      for (int j = 0; j < 1024; j++) mdl[i][j] = '0;
    end
    #1 rst_b = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput("reset_data_out", i, rdata[i], 32'h0);
      checkOutput("reset_err", i, 32'(err[i]), 32'h0);
    end
    #1 rst_b = 1'b1;

    $display("[TB] zeroing words 0..63 in each instance");
    for (int i = 0; i < NI; i++)
      for (int wi = 0; wi < 64; wi++) doOp(i, 1'b1, 32'(wi * 4), 32'h0);

    $display("[TB] single-cycle store/load of DEADBEEF");
    doOp(0, 1'b1, 32'h10, 32'hDEADBEEF);
    doOp(0, 1'b0, 32'h10, 32'h0);
    checkOutput("deadbeef_lanes", 0, rdata[0], 32'hDEADBEEF);

    $display("[TB] latency 4 load with a request pulsed during BUSY");
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    idle(1);
    applyStimulus(2, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
    idle(5);

    $display("[TB] back-to-back stores and loads at latency 1");
    for (int wi = 0; wi < 8; wi++) applyStimulus(0, 1'b1, 1'b1, 32'(wi * 4), $urandom, 1'b0);
    for (int wi = 0; wi < 8; wi++) applyStimulus(0, 1'b1, 1'b0, 32'(wi * 4), 32'h0, 1'b0);
    idle(2);

    $display("[TB] halted raised after an accepted store at latency 3");
    applyStimulus(1, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0);
    repeat (6) applyStimulus(1, 1'b1, 1'b1, 32'h34, 32'h11111111, 1'b1);
    idle(2);
    doOp(1, 1'b0, 32'h30, 32'h0);
    checkOutput("halt_store_kept", 1, rdata[1], 32'hCAFEF00D);

    $display("[TB] reset during BUSY of a store at latency 4");
    applyStimulus(2, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0);
    idle(1);
    applyReset(3);
    doOp(2, 1'b0, 32'h40, 32'h0);
    checkOutput("reset_dropped_store", 2, rdata[2], 32'h0);

    $display("[TB] misaligned and out-of-range addresses");
    for (int i = 0; i < 2; i++) begin
      doOp(i, 1'b1, 32'h0, 32'hA5A5A5A5);
      doOp(i, 1'b0, 32'h13, 32'h0);
      doOp(i, 1'b1, 32'h1000, 32'h5A5A5A5A);
      doOp(i, 1'b0, 32'h0, 32'h0);
`ifdef DATA_MEM_ERR_EN
      checkOutput("no_wrap_word0", i, rdata[i], 32'hA5A5A5A5);
`else
      checkOutput("wrap_word0", i, rdata[i], 32'h5A5A5A5A);
`endif
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 80; n++) begin
        r = ($urandom_range(0, 9) < 7);
        w = $urandom_range(0, 1) == 1;
        a = 32'($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        else if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
        d = $urandom;
        h = ($urandom_range(0, 9) == 0);
        applyStimulus(i, r, w, a, d, h);
      end
      idle(6);
    end

    checkOutput("queue_drained", 0, 32'(expq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
